reg_read_scoreboard: RTL and testbench



---
 rtl/core_pkg.sv | 11 +
 rtl/sb_counter_bank.sv | 72 +++++++
 rtl/reg_read_scoreboard.sv | 146 ++++++++++++++
 tb/tb_reg_read_scoreboard.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared core constants for the decode/issue register-read slice.
//   XLEN      : integer data width
//   REG_IDX_W : architectural register index width
//   REG_COUNT : number of integer registers
//   CNT_W     : default pending-write counter width per register
package core_pkg;
  localparam int unsigned XLEN      = 32;
  localparam int unsigned REG_IDX_W = 5;
  localparam int unsigned REG_COUNT = 32;
  localparam int unsigned CNT_W     = 2;
endpackage

// File: rtl/sb_counter_bank.sv
// Bank of REG_COUNT saturating up/down pending-write counters.
// One increment strobe plus two independent decrement strobes per cycle;
// the result is floored at 0 and clamped at all-ones.
// Ports:
//   clk, rst                     clock, async active-high reset (counters -> 0)
//   inc_en_i / inc_idx_i         increment request
//   dec_a_en_i / dec_a_idx_i     first decrement request (writeback)
//   dec_b_en_i / dec_b_idx_i     second decrement request (slot flush)
//   rs1/rs2/rd_idx_i -> *_cnt_o  three combinational indexed reads
module sb_counter_bank
  import core_pkg::*;
#(
  parameter int unsigned CNT_W = core_pkg::CNT_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inc_en_i,
  input  logic [REG_IDX_W-1:0] inc_idx_i,
  input  logic                 dec_a_en_i,
  input  logic [REG_IDX_W-1:0] dec_a_idx_i,
  input  logic                 dec_b_en_i,
  input  logic [REG_IDX_W-1:0] dec_b_idx_i,
  input  logic [REG_IDX_W-1:0] rs1_idx_i,
  input  logic [REG_IDX_W-1:0] rs2_idx_i,
  input  logic [REG_IDX_W-1:0] rd_idx_i,
  output logic [CNT_W-1:0]     rs1_cnt_o,
  output logic [CNT_W-1:0]     rs2_cnt_o,
  output logic [CNT_W-1:0]     rd_cnt_o
);

  localparam logic [CNT_W+1:0] CNT_MAX = {2'b00, {CNT_W{1'b1}}};

  logic [REG_COUNT-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W+1:0]                up, down, nxt;
  logic                            inc_hit, dec_a_hit, dec_b_hit;

  // Widened by two bits so +1 and -2 can be resolved before flooring/clamping.
  always_comb begin
    cnt_d     = cnt_q;
    up        = '0;
    down      = '0;
    nxt       = '0;
    inc_hit   = 1'b0;
    dec_a_hit = 1'b0;
    dec_b_hit = 1'b0;
    for (int unsigned i = 0; i < REG_COUNT; i++) begin
      inc_hit   = inc_en_i   && (inc_idx_i   == REG_IDX_W'(i));
      dec_a_hit = dec_a_en_i && (dec_a_idx_i == REG_IDX_W'(i));
      dec_b_hit = dec_b_en_i && (dec_b_idx_i == REG_IDX_W'(i));
      up   = {2'b00, cnt_q[i]} + {{(CNT_W+1){1'b0}}, inc_hit};
      down = {{(CNT_W+1){1'b0}}, dec_a_hit} + {{(CNT_W+1){1'b0}}, dec_b_hit};
      nxt  = (up > down) ? (up - down) : '0;
      if (nxt > CNT_MAX) begin
        nxt = CNT_MAX;
      end
      cnt_d[i] = nxt[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign rs1_cnt_o = cnt_q[rs1_idx_i];
  assign rs2_cnt_o = cnt_q[rs2_idx_i];
  assign rd_cnt_o  = cnt_q[rd_idx_i];

endmodule

// File: rtl/reg_read_scoreboard.sv
// Register-read / scoreboard stage at the decode->issue boundary.
// Blocks instructions whose sources have pending writes (or whose rd counter
// is saturated), reads operands from the register file and registers them
// into a single issue slot. Writeback and slot flush release pending writes.
// Optional build macro: SCOREBOARD_WB_BYPASS_EN -- waive a source hazard when
// the last pending write to that source retires this cycle; the operand is
// then taken from wb_data.
// Ports:
//   clk, rst                         clock, async active-high reset
//   in_* / in_ready                  decoded instruction handshake
//   rf_a1/rf_a2 -> rf_rd1/rf_rd2      register file read ports
//   wb_valid/wb_rd/wb_data           writeback retirement
//   out_* / out_ready                issue slot toward execute
//   flush                            kill the issue slot
module reg_read_scoreboard
  import core_pkg::*;
#(
  parameter int unsigned XLEN  = core_pkg::XLEN,
  parameter int unsigned CNT_W = core_pkg::CNT_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [REG_IDX_W-1:0] in_rs1,
  input  logic [REG_IDX_W-1:0] in_rs2,
  input  logic                 in_use_rs1,
  input  logic                 in_use_rs2,
  input  logic [REG_IDX_W-1:0] in_rd,
  input  logic                 in_rd_we,
  output logic [REG_IDX_W-1:0] rf_a1,
  output logic [REG_IDX_W-1:0] rf_a2,
  input  logic [XLEN-1:0]      rf_rd1,
  input  logic [XLEN-1:0]      rf_rd2,
  input  logic                 wb_valid,
  input  logic [REG_IDX_W-1:0] wb_rd,
  input  logic [XLEN-1:0]      wb_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      out_op1,
  output logic [XLEN-1:0]      out_op2,
  output logic [REG_IDX_W-1:0] out_rd,
  output logic                 out_rd_we,
  input  logic                 flush
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0]     pend_rs1, pend_rs2, pend_rd;
  logic                 byp1, byp2, haz1, haz2, sat, blocked, accept;
  logic                 inc_en, wb_dec_en, flush_dec_en;
  logic [XLEN-1:0]      op1, op2;

  logic                 out_valid_q, out_valid_d;
  logic [XLEN-1:0]      out_op1_q, out_op1_d, out_op2_q, out_op2_d;
  logic [REG_IDX_W-1:0] out_rd_q, out_rd_d;
  logic                 out_rd_we_q, out_rd_we_d;

  assign rf_a1 = in_rs1;
  assign rf_a2 = in_rs2;

`ifdef SCOREBOARD_WB_BYPASS_EN
  assign byp1 = in_use_rs1 && (in_rs1 != '0) && wb_valid && (wb_rd == in_rs1) && (pend_rs1 == CNT_ONE);
  assign byp2 = in_use_rs2 && (in_rs2 != '0) && wb_valid && (wb_rd == in_rs2) && (pend_rs2 == CNT_ONE);
`else
  assign byp1 = 1'b0;
  assign byp2 = 1'b0;
`endif

  assign haz1    = in_use_rs1 && (in_rs1 != '0) && (pend_rs1 != '0) && !byp1;
  assign haz2    = in_use_rs2 && (in_rs2 != '0) && (pend_rs2 != '0) && !byp2;
  assign sat     = in_rd_we && (in_rd != '0) && (pend_rd == '1);
  assign blocked = haz1 || haz2 || sat;

  assign in_ready = !blocked && !flush && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  assign op1 = byp1 ? wb_data : rf_rd1;
  assign op2 = byp2 ? wb_data : rf_rd2;

  assign inc_en       = accept && in_rd_we && (in_rd != '0);
  assign wb_dec_en    = wb_valid && (wb_rd != '0);
  // A flushed writer never reaches writeback, so its reservation is dropped here.
  assign flush_dec_en = flush && out_valid_q && out_rd_we_q && (out_rd_q != '0);

  sb_counter_bank #(
    .CNT_W (CNT_W)
  ) u_bank (
    .clk         (clk),
    .rst         (rst),
    .inc_en_i    (inc_en),
    .inc_idx_i   (in_rd),
    .dec_a_en_i  (wb_dec_en),
    .dec_a_idx_i (wb_rd),
    .dec_b_en_i  (flush_dec_en),
    .dec_b_idx_i (out_rd_q),
    .rs1_idx_i   (in_rs1),
    .rs2_idx_i   (in_rs2),
    .rd_idx_i    (in_rd),
    .rs1_cnt_o   (pend_rs1),
    .rs2_cnt_o   (pend_rs2),
    .rd_cnt_o    (pend_rd)
  );

  always_comb begin
    out_valid_d = out_valid_q;
    out_op1_d   = out_op1_q;
    out_op2_d   = out_op2_q;
    out_rd_d    = out_rd_q;
    out_rd_we_d = out_rd_we_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d = 1'b1;
      out_op1_d   = op1;
      out_op2_d   = op2;
      out_rd_d    = in_rd;
      out_rd_we_d = in_rd_we;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_op1_q   <= '0;
      out_op2_q   <= '0;
      out_rd_q    <= '0;
      out_rd_we_q <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_op1_q   <= out_op1_d;
      out_op2_q   <= out_op2_d;
      out_rd_q    <= out_rd_d;
      out_rd_we_q <= out_rd_we_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_op1   = out_op1_q;
  assign out_op2   = out_op2_q;
  assign out_rd    = out_rd_q;
  assign out_rd_we = out_rd_we_q;

endmodule

// File: tb/tb_reg_read_scoreboard.sv
// Bench for reg_read_scoreboard: directed stimulus with a register-file model
// (combinational read, negedge write); expected issue-slot contents are queued
// when an instruction is expected to be accepted and popped by a monitor
// whenever the slot is consumed by execute.
module tb_reg_read_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic        in_use_rs1, in_use_rs2, in_rd_we;
  logic [4:0]  rf_a1, rf_a2;
  logic [31:0] rf_rd1, rf_rd2;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        out_valid, out_ready;
  logic [31:0] out_op1, out_op2;
  logic [4:0]  out_rd;
  logic        out_rd_we;
  logic        flush;

  always #5 clk = ~clk;

  reg_read_scoreboard #(
    .XLEN  (32),
    .CNT_W (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_rs1     (in_rs1),
    .in_rs2     (in_rs2),
    .in_use_rs1 (in_use_rs1),
    .in_use_rs2 (in_use_rs2),
    .in_rd      (in_rd),
    .in_rd_we   (in_rd_we),
    .rf_a1      (rf_a1),
    .rf_a2      (rf_a2),
    .rf_rd1     (rf_rd1),
    .rf_rd2     (rf_rd2),
    .wb_valid   (wb_valid),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_op1    (out_op1),
    .out_op2    (out_op2),
    .out_rd     (out_rd),
    .out_rd_we  (out_rd_we),
    .flush      (flush)
  );

  // Register file model: xN starts as 0x100+N, x0 reads 0.
  logic [31:0] rf [32];
  logic        rf_loaded = 1'b0;
  always @(negedge clk) begin
    if (!rf_loaded) begin
      for (int i = 0; i < 32; i++) rf[i] <= 32'h100 + 32'(i);
      rf_loaded <= 1'b1;
    end else if (wb_valid && wb_rd != 5'd0) begin
      rf[wb_rd] <= wb_data;
    end
  end
  assign rf_rd1 = (rf_a1 == 5'd0) ? 32'd0 : rf[rf_a1];
  assign rf_rd2 = (rf_a2 == 5'd0) ? 32'd0 : rf[rf_a2];

  typedef struct {
    logic [31:0] op1;
    logic [31:0] op2;
    logic [4:0]  rd;
    logic        we;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: the slot is consumed when valid, ready and not flushed.
  always @(negedge clk) begin
    if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1 && flush === 1'b0) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_issue: got rd %0d expected no issue", out_rd);
      end else begin
        e = q.pop_front();
        check("issue_op1", out_op1, e.op1);
        check("issue_op2", out_op2, e.op2);
        check("issue_rd", 32'(out_rd), 32'(e.rd));
        check("issue_rd_we", 32'(out_rd_we), 32'(e.we));
      end
    end
  end

  task automatic set_in(input logic v, input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2,
                        input logic [4:0] rd, input logic we);
    in_valid = v; in_rs1 = rs1; in_use_rs1 = u1;
    in_rs2 = rs2; in_use_rs2 = u2; in_rd = rd; in_rd_we = we;
  endtask

  task automatic idle();
    set_in(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic set_wb(input logic v, input logic [4:0] rd, input logic [31:0] d);
    wb_valid = v; wb_rd = rd; wb_data = d;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd, input logic we);
    q.push_back('{op1: a, op2: b, rd: rd, we: we});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst = 1'b1;
    idle();
    set_wb(1'b0, 5'd0, 32'd0);
    out_ready = 1'b1;
    flush = 1'b0;
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_op1", out_op1, 32'd0);
    check("rst_out_op2", out_op2, 32'd0);
    check("rst_out_rd", 32'(out_rd), 32'd0);
    check("rst_out_rd_we", 32'(out_rd_we), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Mid-stream reset with pend[5] = 2 and the slot full.
    set_in(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1);
    #1; check("t1_w5a_rdy", 32'(in_ready), 32'd1); push(32'h101, 32'd0, 5'd5, 1'b1);
    step();
    set_in(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1);
    #1; check("t1_w5b_rdy", 32'(in_ready), 32'd1); push(32'h102, 32'd0, 5'd5, 1'b1);
    step();
    idle();
    out_ready = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    check("t1_async_valid", 32'(out_valid), 32'd0);
    check("t1_async_rd", 32'(out_rd), 32'd0);
    check("t1_async_op1", out_op1, 32'd0);
    q.delete();
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    set_in(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd6, 1'b1);
    #1; check("t1_add_x6_rdy", 32'(in_ready), 32'd1); push(32'h101, 32'h102, 5'd6, 1'b1);
    step();
    check("t1_latency", 32'(out_valid), 32'd1);
    set_in(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    #1; check("t1_pend5_cleared", 32'(in_ready), 32'd1); push(32'h105, 32'd0, 5'd0, 1'b0);
    step();
    idle();

    // RAW hazard on x5 released by writeback.
    set_in(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1);
    #1; check("t2_addi_rdy", 32'(in_ready), 32'd1); push(32'h101, 32'd0, 5'd5, 1'b1);
    step();
    set_in(1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd7, 1'b1);
    #1; check("t2_stall0", 32'(in_ready), 32'd0);
    step();
    #1; check("t2_stall1", 32'(in_ready), 32'd0);
    set_wb(1'b1, 5'd5, 32'hDEADBEEF);
    #1;
`ifdef SCOREBOARD_WB_BYPASS_EN
    check("t2_bypass_rdy", 32'(in_ready), 32'd1); push(32'hDEADBEEF, 32'h101, 5'd7, 1'b1);
    step();
    set_wb(1'b0, 5'd0, 32'd0);
`else
    check("t2_wb_cycle_rdy", 32'(in_ready), 32'd0);
    step();
    set_wb(1'b0, 5'd0, 32'd0);
    #1; check("t2_after_wb_rdy", 32'(in_ready), 32'd1); push(32'hDEADBEEF, 32'h101, 5'd7, 1'b1);
    step();
`endif
    idle();

    // Counter saturation on x3.
    for (int k = 0; k < 3; k++) begin
      set_in(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1);
      #1; check("t3_w3_rdy", 32'(in_ready), 32'd1); push(32'd0, 32'd0, 5'd3, 1'b1);
      step();
    end
    #1; check("t3_sat_rdy", 32'(in_ready), 32'd0);
    step();
    set_wb(1'b1, 5'd3, 32'h33);
    #1; check("t3_sat_wb_cycle", 32'(in_ready), 32'd0);
    step();
    set_wb(1'b0, 5'd0, 32'd0);
    #1; check("t3_released", 32'(in_ready), 32'd1); push(32'd0, 32'd0, 5'd3, 1'b1);
    step();
    idle();

    // Writeback to a zero counter must not underflow.
    set_wb(1'b1, 5'd8, 32'h88);
    step();
    set_wb(1'b0, 5'd0, 32'd0);
    set_in(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd8, 1'b1);
    #1; check("t3_no_underflow", 32'(in_ready), 32'd1); push(32'd0, 32'd0, 5'd8, 1'b1);
    step();
    idle();

    // Same-cycle increment and decrement of x4.
    set_in(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1);
    #1; check("t4_w4_rdy", 32'(in_ready), 32'd1); push(32'd0, 32'd0, 5'd4, 1'b1);
    step();
    set_wb(1'b1, 5'd4, 32'h44);
    #1; check("t4_inc_dec_rdy", 32'(in_ready), 32'd1); push(32'd0, 32'd0, 5'd4, 1'b1);
    step();
    set_wb(1'b0, 5'd0, 32'd0);
    set_in(1'b1, 5'd4, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    #1; check("t4_pend_still1", 32'(in_ready), 32'd0);
    step();
    idle();
    set_wb(1'b1, 5'd4, 32'h45);
    step();
    set_wb(1'b0, 5'd0, 32'd0);
    set_in(1'b1, 5'd4, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    #1; check("t4_pend_zero", 32'(in_ready), 32'd1); push(32'h45, 32'd0, 5'd0, 1'b0);
    step();
    idle();

    // Backpressure from execute.
    set_in(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd10, 1'b1);
    #1; check("t5_w10_rdy", 32'(in_ready), 32'd1); push(32'h101, 32'd0, 5'd10, 1'b1);
    step();
    out_ready = 1'b0;
    set_in(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd11, 1'b1);
    for (int k = 0; k < 3; k++) begin
      #1;
      check("t5_bp_rdy", 32'(in_ready), 32'd0);
      check("t5_hold_rd", 32'(out_rd), 32'd10);
      check("t5_hold_op1", out_op1, 32'h101);
      step();
    end
    out_ready = 1'b1;
    #1; check("t5_release_rdy", 32'(in_ready), 32'd1); push(32'h102, 32'd0, 5'd11, 1'b1);
    step();
    idle();

    // Flush a slot holding a writer to x9.
    set_in(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1);
    #1; check("t6_w9_rdy", 32'(in_ready), 32'd1);
    step();
    flush = 1'b1;
    set_in(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd12, 1'b1);
    #1; check("t6_flush_rdy", 32'(in_ready), 32'd0);
    step();
    flush = 1'b0;
    set_in(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    #1;
    check("t6_flushed_valid", 32'(out_valid), 32'd0);
    check("t6_x9_free_rdy", 32'(in_ready), 32'd1); push(32'h109, 32'd0, 5'd0, 1'b0);
    step();
    idle();
    check("t6_reader_issued", 32'(out_valid), 32'd1);

    repeat (3) step();
    check("drain_queue_empty", 32'(q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
